imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Write-side counterpart of the single-cycle CPU instruction memory. Accepts a byte
//  stream over a valid/ready handshake and packs it little-endian into 32-bit words.
//  Issues one synchronous word write per word to the imem write port, replacing
//  $readmemh preloading. Holds the CPU in reset until the image is fully written.
// PARAMETERS
//  MEM_DEPTH  1024  words in target imem; word index wraps never, overflow is flagged
//  BASE_ADDR  0     byte address of first word written (must be 4-aligned)
// PORTS
//  clk         in   1   clock
//  reset       in   1   synchronous, active-high
//  start       in   1   pulse: begin new load (honoured only in IDLE/DONE)
//  byte_valid  in   1   byte_data valid
//  byte_data   in   8   stream byte, LSB of word first
//  byte_last   in   1   qualifies final byte of image (with byte_valid)
//  byte_ready  out  1   loader accepts byte this cycle
//  imem_we     out  1   word write strobe, one cycle per word
//  imem_addr   out  32  byte address of write (BASE_ADDR + 4*word_idx)
//  imem_wdata  out  32  packed word
//  busy        out  1   load in progress (RECV or WRITE)
//  done        out  1   sticky: image complete
//  overflow    out  1   sticky: image exceeded MEM_DEPTH words
//  cpu_hold    out  1   hold CPU in reset; low only in DONE
//  word_count  out  11  words committed this load (clog2(MEM_DEPTH)+1 bits)
// BEHAVIOUR
//  Reset: state=IDLE; byte_ready/imem_we/busy/done/overflow=0; cpu_hold=1;
//   imem_addr=BASE_ADDR; imem_wdata=0; word_count=0; byte counter=0.
//   Reset mid-load aborts immediately; partial word discarded.
//  Byte accepted iff byte_valid & byte_ready (same posedge).
//  FSM: IDLE -start-> RECV (clear counters, done, overflow, wdata)
//   RECV: byte_ready=1; byte k (0..3) goes to wdata[8k+7:8k]; on accept of k==3
//    or byte_last -> WRITE.
//   WRITE: byte_ready=0; imem_we=1 for exactly this cycle (addr/wdata stable);
//    word_count++; byte counter=0; wdata cleared after. -> DONE if last seen, else RECV.
//   DONE: done=1, cpu_hold=0; start -> RECV (new load, cpu_hold=1 again).
//  Latency: write strobe is the cycle after the 4th (or last) byte accept; max
//   throughput 4 bytes per 5 cycles.
//  Partial final word: unreceived bytes written as 0x00.
//  byte_last with zero bytes pending is impossible (last always in RECV, so >=1 byte).
//  Overflow: if word_count==MEM_DEPTH at WRITE, imem_we suppressed, overflow=1,
//   word_count saturates; loader keeps draining bytes until byte_last -> DONE.
//  start while RECV/WRITE ignored; byte_valid in IDLE/DONE not accepted (ready=0).
//  imem_addr = BASE_ADDR + {word_count,2'b00}, 32-bit, no wrap.
// CONFIGURATION
//  IMEM_LOADER_CSUM_EN defined: extra port csum_err (out,1). Running 8-bit sum of
//   all accepted bytes incl. byte_last byte; image is valid iff sum==8'h00.
//   csum_err set on entering DONE if sum!=0, cleared on reset/start; cpu_hold stays 1
//   when csum_err=1. Undefined: no checksum logic, port absent.
// STRUCTURE
//  Shared package/include: state encoding localparams (IDLE,RECV,WRITE,DONE), WORD_BYTES=4.
//  Sub-module imem_byte_packer (byte counter + shift/pack of wdata, clear, full flag);
//  FSM, address/count and flags stay in top.
// TESTING
//  1. start; bytes 13,00,00,00,93,00,10,00(last) -> we@addr 0 data 00000013,
//     we@addr 4 data 00100093; done=1, cpu_hold=0, word_count=2.
//  2. bytes AA,BB,CC(last) -> single write 00CCBBAA; partial zero-fill.
//  3. byte_valid toggled randomly, 3 words -> exactly 3 we pulses, no byte lost,
//     byte_ready=0 on each WRITE cycle.
//  4. MEM_DEPTH=4, 6 words streamed -> 4 writes (addr 0..C), overflow=1, done after last.
//  5. reset asserted after 2 bytes of word 1 -> all outputs at reset values next
//     cycle, no we; fresh start loads word at addr 0.
//  6. CSUM_EN: bytes 01,02,03,FA(last) -> csum_err=0, cpu_hold=0; last=FB -> csum_err=1,
//     cpu_hold=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader:
//   - loader FSM state encoding (IDLE, RECV, WRITE, DONE)
//   - word geometry (WORD_BYTES bytes per imem word, byte-lane index width)
// Imported by imem_loader and imem_byte_packer.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_IDX_W = $clog2(WORD_BYTES);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_RECV  = RECV,
        ST_WRITE = WRITE,
        ST_DONE  = DONE
    } state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// -----------------------------------------------------------------------------
// imem_byte_packer
// Packs a byte stream little-endian into one imem word. Byte k of a word lands
// in wdata[8k+7:8k]; lanes not yet written in the current word read as 0x00, so
// a short final word comes out zero-filled.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset (clears counter and lanes)
//   clear      in   discard current word: counter and all lanes to zero
//   load       in   accept byte_data into the current lane, advance counter
//   byte_data  in   [7:0] incoming byte
//   full       out  the next load fills the last lane of the word
//   wdata      out  [31:0] packed word
// -----------------------------------------------------------------------------
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    load,
    input  logic [7:0]              byte_data,
    output logic                    full,
    output logic [8*WORD_BYTES-1:0] wdata
);

    logic [BYTE_IDX_W-1:0] byte_idx_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_idx_reg <= '0;
        end else if (load) begin
            byte_idx_reg <= byte_idx_reg + 1'b1;
        end
    end

    assign full = (byte_idx_reg == BYTE_IDX_W'(WORD_BYTES - 1));

    // One register per byte lane; only the lane selected by the counter loads.
    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    lane_reg <= 8'h00;
                end else if (load && (byte_idx_reg == BYTE_IDX_W'(gi))) begin
                    lane_reg <= byte_data;
                end
            end

            assign wdata[8*gi +: 8] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Write-side loader for the single-cycle CPU instruction memory. Receives a
// byte stream (valid/ready), packs it little-endian into 32-bit words and
// issues one imem write per word at BASE_ADDR + 4*word_index. The CPU is held
// in reset (cpu_hold=1) until the whole image has been written.
// Parameters:
//   MEM_DEPTH  words in target imem; words past this are dropped, overflow set
//   BASE_ADDR  byte address of the first word (4-aligned)
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      begin a new load (only acted on in IDLE/DONE)
//   byte_valid/data/last       input byte stream, byte_last marks final byte
//   byte_ready                 loader takes the byte this cycle
//   imem_we/addr/wdata         one-cycle word write strobe, address, data
//   busy                       load in progress
//   done                       sticky: image complete
//   overflow                   sticky: image longer than MEM_DEPTH words
//   cpu_hold                   keep CPU in reset; low only in DONE
//   word_count                 words committed during this load
//   csum_err (option)          image byte sum != 0 (IMEM_LOADER_CSUM_EN only)
// Build option: define IMEM_LOADER_CSUM_EN to add the 8-bit checksum check
// and the csum_err port; a failed checksum keeps cpu_hold high in DONE.
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MEM_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      byte_valid,
    input  logic [7:0]                byte_data,
    input  logic                      byte_last,
    output logic                      byte_ready,
    output logic                      imem_we,
    output logic [31:0]               imem_addr,
    output logic [31:0]               imem_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic                      cpu_hold,
    output logic [$clog2(MEM_DEPTH):0] word_count
`ifdef IMEM_LOADER_CSUM_EN
    ,
    output logic                      csum_err
`endif
);

    localparam int               CNT_W     = $clog2(MEM_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(MEM_DEPTH);

    state_t           state_reg;
    logic             byte_ready_reg;
    logic             imem_we_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             overflow_reg;
    logic             cpu_hold_reg;
    logic             last_seen_reg;
    logic [CNT_W-1:0] word_count_reg;

    logic             accept;
    logic             start_ok;
    logic             pack_clear;
    logic             pack_full;
    logic             csum_bad;

    assign accept     = byte_valid && byte_ready_reg;
    assign start_ok   = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    // The word is consumed by the WRITE cycle; a new load also drops leftovers.
    assign pack_clear = start_ok || (state_reg == ST_WRITE);

    imem_byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pack_clear),
        .load      (accept),
        .byte_data (byte_data),
        .full      (pack_full),
        .wdata     (imem_wdata)
    );

`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] csum_reg;
    logic       csum_err_reg;

    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            csum_reg     <= 8'h00;
            csum_err_reg <= 1'b0;
        end else begin
            if (accept) begin
                csum_reg <= csum_reg + byte_data;
            end
            // The final byte was summed during RECV, so the sum is complete
            // by the WRITE cycle that leads into DONE.
            if ((state_reg == ST_WRITE) && last_seen_reg) begin
                csum_err_reg <= (csum_reg != 8'h00);
            end
        end
    end

    assign csum_bad = (csum_reg != 8'h00);
    assign csum_err = csum_err_reg;
`else
    assign csum_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            byte_ready_reg <= 1'b0;
            imem_we_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
            cpu_hold_reg   <= 1'b1;
            last_seen_reg  <= 1'b0;
            word_count_reg <= '0;
        end else begin
            imem_we_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg      <= ST_RECV;
                        byte_ready_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                        done_reg       <= 1'b0;
                        overflow_reg   <= 1'b0;
                        cpu_hold_reg   <= 1'b1;
                        last_seen_reg  <= 1'b0;
                        word_count_reg <= '0;
                    end
                end
                ST_RECV: begin
                    if (accept && (pack_full || byte_last)) begin
                        state_reg      <= ST_WRITE;
                        byte_ready_reg <= 1'b0;
                        last_seen_reg  <= byte_last;
                        // Memory already full: drop the word, keep draining.
                        if (word_count_reg == DEPTH_CNT) begin
                            overflow_reg <= 1'b1;
                        end else begin
                            imem_we_reg  <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (word_count_reg != DEPTH_CNT) begin
                        word_count_reg <= word_count_reg + 1'b1;
                    end
                    if (last_seen_reg) begin
                        state_reg    <= ST_DONE;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        cpu_hold_reg <= csum_bad;
                    end else begin
                        state_reg      <= ST_RECV;
                        byte_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_reg;
    assign imem_we    = imem_we_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign overflow   = overflow_reg;
    assign cpu_hold   = cpu_hold_reg;
    assign word_count = word_count_reg;
    assign imem_addr  = BASE_ADDR + 32'({word_count_reg, 2'b00});

endmodule
